float_byte_assembler: RTL and testbench

FLOAT_BYTE_ASSEMBLER -- requirements
Module: float_byte_assembler

---
 rtl/float_byte_assembler.sv | 133 +++++++++++++
 tb/tb_float_byte_assembler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_byte_assembler.sv
// Collects four bytes into an IEEE754 single-precision word for the float-to-fixed
// converter, flags inf/NaN and +/-0, and drops partial words that stall too long.
//
// state | meaning
// B0    | waiting for byte 0 of a word
// B1    | byte 0 collected, waiting for byte 1
// B2    | bytes 0..1 collected, waiting for byte 2
// B3    | bytes 0..2 collected, waiting for byte 3 (completes the word)
module float_byte_assembler #(
   parameter int BIG_ENDIAN = 0,
   parameter int TIMEOUT    = 1000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [7:0]  i_byte,
   output logic        o_valid,
   input  logic        o_ready,
   output logic [31:0] o_data,
   output logic        o_special,
   output logic        o_zero,
   output logic        o_timeout,
   output logic [15:0] o_word_cnt
);

   localparam int            CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Expiry is detected on the edge where the counter would reach TIMEOUT.
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2,
      B3 = 2'd3
   } state_t;

   state_t        r_state;
   logic [31:0]   r_collect;
   logic [CW-1:0] r_cnt;
   logic          r_o_valid;
   logic [31:0]   r_o_data;
   logic          r_o_special;
   logic          r_o_zero;
   logic          r_o_timeout;
   logic [15:0]   r_word_cnt;

   logic [31:0]   w_collect_nxt;
   logic [1:0]    w_lane;
   logic          w_in_hs;
   logic          w_out_hs;
   logic          w_last;
   logic          w_expire;

   assign i_ready    = !r_o_valid || o_ready;
   assign w_in_hs    = i_valid && i_ready;
   assign w_out_hs   = r_o_valid && o_ready;
   assign w_last     = w_in_hs && (r_state == B3);
   assign w_lane     = (BIG_ENDIAN != 0) ? ~2'(r_state) : 2'(r_state);
   // A byte arriving on the expiry cycle wins over the timeout.
   assign w_expire   = (TIMEOUT != 0) && (r_state != B0) && !w_in_hs && (r_cnt == TC);

   assign o_valid    = r_o_valid;
   assign o_data     = r_o_data;
   assign o_special  = r_o_special;
   assign o_zero     = r_o_zero;
   assign o_timeout  = r_o_timeout;
   assign o_word_cnt = r_word_cnt;

   always_comb begin
      w_collect_nxt = r_collect;
      case (w_lane)
         2'd0:    w_collect_nxt[7:0]   = i_byte;
         2'd1:    w_collect_nxt[15:8]  = i_byte;
         2'd2:    w_collect_nxt[23:16] = i_byte;
         default: w_collect_nxt[31:24] = i_byte;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= B0;
         r_collect   <= '0;
         r_cnt       <= '0;
         r_o_valid   <= 1'b0;
         r_o_data    <= '0;
         r_o_special <= 1'b0;
         r_o_zero    <= 1'b0;
         r_o_timeout <= 1'b0;
         r_word_cnt  <= '0;
      end else begin
         if (w_in_hs) begin
            case (r_state)
               B0:      r_state <= B1;
               B1:      r_state <= B2;
               B2:      r_state <= B3;
               default: r_state <= B0;
            endcase
         end else if (w_expire) begin
            r_state <= B0;
         end

         if (w_last || w_expire) begin
            r_collect <= '0;
         end else if (w_in_hs) begin
            r_collect <= w_collect_nxt;
         end

         if ((r_state == B0) || w_in_hs || w_expire) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end

         // A new word may replace the one handshaking out in the same cycle.
         if (w_last) begin
            r_o_valid   <= 1'b1;
            r_o_data    <= w_collect_nxt;
            r_o_special <= &w_collect_nxt[30:23];
            r_o_zero    <= ~|w_collect_nxt[30:0];
         end else if (w_out_hs) begin
            r_o_valid   <= 1'b0;
         end

         r_o_timeout <= w_expire;

         if (w_out_hs) begin
            r_word_cnt <= r_word_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_float_byte_assembler.sv
// Scoreboard bench: little- and big-endian instances share one byte stream; each
// expected word is queued at issue and popped by a monitor on output handshakes.
module tb_float_byte_assembler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_valid;
   logic [7:0]  i_byte;
   logic        o_ready;

   logic        le_i_ready, le_o_valid, le_o_special, le_o_zero, le_o_timeout;
   logic [31:0] le_o_data;
   logic [15:0] le_o_word_cnt;
   logic        be_i_ready, be_o_valid, be_o_special, be_o_zero, be_o_timeout;
   logic [31:0] be_o_data;
   logic [15:0] be_o_word_cnt;

   typedef struct packed {
      logic [31:0] d;
      logic        sp;
      logic        z;
   } exp_t;

   exp_t        q_le[$];
   exp_t        q_be[$];
   exp_t        e_le;
   exp_t        e_be;
   logic [15:0] m_cnt_le;
   logic [15:0] m_cnt_be;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   float_byte_assembler #(.BIG_ENDIAN(0), .TIMEOUT(8)) dut_le (
      .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(le_i_ready), .i_byte(i_byte),
      .o_valid(le_o_valid), .o_ready(o_ready), .o_data(le_o_data), .o_special(le_o_special),
      .o_zero(le_o_zero), .o_timeout(le_o_timeout), .o_word_cnt(le_o_word_cnt)
   );

   float_byte_assembler #(.BIG_ENDIAN(1), .TIMEOUT(8)) dut_be (
      .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(be_i_ready), .i_byte(i_byte),
      .o_valid(be_o_valid), .o_ready(o_ready), .o_data(be_o_data), .o_special(be_o_special),
      .o_zero(be_o_zero), .o_timeout(be_o_timeout), .o_word_cnt(be_o_word_cnt)
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] w);
      exp_t r;
      r.d  = w;
      r.sp = (w[30:23] == 8'hFF);
      r.z  = (w[30:0] == 31'd0);
      return r;
   endfunction

   task automatic push_exp(input logic [7:0] b0, b1, b2, b3);
      q_le.push_back(mk({b3, b2, b1, b0}));
      q_be.push_back(mk({b0, b1, b2, b3}));
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit hs;
      int n;
      hs = 1'b0;
      n  = 0;
      @(negedge clk);
      i_valid = 1'b1;
      i_byte  = b;
      while (!hs && n < 100) begin
         hs = le_i_ready;
         @(posedge clk);
         if (!hs) @(negedge clk);
         n++;
      end
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL send_byte: byte %h not accepted within 100 cycles", b);
      end
   endtask

   task automatic send4(input logic [7:0] b0, b1, b2, b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
   endtask

   task automatic send_word(input logic [7:0] b0, b1, b2, b3);
      push_exp(b0, b1, b2, b3);
      send4(b0, b1, b2, b3);
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn    = 1'b0;
      i_valid = 1'b0;
      q_le.delete();
      q_be.delete();
      m_cnt_le = '0;
      m_cnt_be = '0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   always @(negedge clk) begin
      #2;
      if (rstn && le_o_valid && o_ready) begin
         if (q_le.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL le_extra_word: got %h expected none", le_o_data);
         end else begin
            e_le = q_le.pop_front();
            chk("le_data", le_o_data, e_le.d);
            chk("le_special", le_o_special, e_le.sp);
            chk("le_zero", le_o_zero, e_le.z);
         end
         chk("le_word_cnt", le_o_word_cnt, m_cnt_le);
         m_cnt_le = m_cnt_le + 16'd1;
      end
   end

   always @(negedge clk) begin
      #2;
      if (rstn && be_o_valid && o_ready) begin
         if (q_be.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL be_extra_word: got %h expected none", be_o_data);
         end else begin
            e_be = q_be.pop_front();
            chk("be_data", be_o_data, e_be.d);
            chk("be_special", be_o_special, e_be.sp);
            chk("be_zero", be_o_zero, e_be.z);
         end
         chk("be_word_cnt", be_o_word_cnt, m_cnt_be);
         m_cnt_be = m_cnt_be + 16'd1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn     = 1'b0;
      i_valid  = 1'b0;
      i_byte   = 8'h00;
      o_ready  = 1'b1;
      m_cnt_le = '0;
      m_cnt_be = '0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_i_ready_le", le_i_ready, 1);
      chk("rst_i_ready_be", be_i_ready, 1);
      chk("rst_o_valid", le_o_valid, 0);
      chk("rst_o_data", le_o_data, 32'h0);
      chk("rst_o_special", le_o_special, 0);
      chk("rst_o_zero", le_o_zero, 0);
      chk("rst_o_timeout", le_o_timeout, 0);
      chk("rst_word_cnt", le_o_word_cnt, 0);
      rstn = 1'b1;
      #1;
      chk("post_rst_i_ready", le_i_ready, 1);

      // 1.0f little-endian, one-cycle latency
      send_word(8'h00, 8'h00, 8'h80, 8'h3F);
      idle();
      chk("t1_valid_latency", le_o_valid, 1);
      chk("t1_le_data", le_o_data, 32'h3F800000);
      chk("t1_le_special", le_o_special, 0);
      chk("t1_le_zero", le_o_zero, 0);
      @(negedge clk);
      chk("t1_word_cnt", le_o_word_cnt, 16'd1);
      chk("t1_valid_cleared", le_o_valid, 0);

      // +inf and -0 big-endian
      send_word(8'h7F, 8'h80, 8'h00, 8'h00);
      idle();
      chk("t2_be_inf_data", be_o_data, 32'h7F800000);
      chk("t2_be_inf_special", be_o_special, 1);
      chk("t2_le_inf_data", le_o_data, 32'h0000807F);
      chk("t2_le_inf_special", le_o_special, 0);
      send_word(8'h80, 8'h00, 8'h00, 8'h00);
      idle();
      chk("t2_be_negz_data", be_o_data, 32'h80000000);
      chk("t2_be_negz_zero", be_o_zero, 1);
      chk("t2_le_negz_zero", le_o_zero, 0);
      send_word(8'hFF, 8'hFF, 8'hC0, 8'h7F);
      idle();
      chk("t2_le_nan_data", le_o_data, 32'h7FC0FFFF);
      chk("t2_le_nan_special", le_o_special, 1);
      @(negedge clk);

      // backpressure: first word held, second follows
      do_reset();
      @(negedge clk);
      o_ready = 1'b0;
      send_word(8'h11, 8'h22, 8'h33, 8'h44);
      @(negedge clk);
      i_valid = 1'b1;
      i_byte  = 8'h55;
      chk("t3_i_ready_low", le_i_ready, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_hold_valid", le_o_valid, 1);
         chk("t3_hold_le_data", le_o_data, 32'h44332211);
         chk("t3_hold_be_data", be_o_data, 32'h11223344);
      end
      o_ready = 1'b1;
      i_valid = 1'b0;
      send_word(8'h55, 8'h66, 8'h77, 8'h88);
      idle();
      @(negedge clk);
      chk("t3_word_cnt", le_o_word_cnt, 16'd2);

      // timeout after two bytes
      do_reset();
      send_byte(8'h01);
      send_byte(8'h02);
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) i_valid = 1'b0;
         chk($sformatf("t4_timeout_k%0d", k), le_o_timeout, (k == 8) ? 1 : 0);
      end
      chk("t4_valid_untouched", le_o_valid, 0);
      send_word(8'h0A, 8'h0B, 8'h0C, 8'h0D);
      idle();
      @(negedge clk);

      // reset with a word pending
      o_ready = 1'b0;
      send4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
      idle();
      chk("t6_pending_valid", le_o_valid, 1);
      rstn = 1'b0;
      q_le.delete();
      q_be.delete();
      m_cnt_le = '0;
      m_cnt_be = '0;
      #1;
      chk("t6_rst_valid", le_o_valid, 0);
      chk("t6_rst_data", le_o_data, 32'h0);
      @(negedge clk);
      rstn    = 1'b1;
      o_ready = 1'b1;
      chk("t6_after_valid", le_o_valid, 0);

      // reset mid-word
      do_reset();
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      do_reset();
      send_word(8'h01, 8'h02, 8'h03, 8'h04);
      idle();
      chk("t5_le_data", le_o_data, 32'h04030201);
      @(negedge clk);
      chk("t5_word_cnt", le_o_word_cnt, 16'd1);

      // word counter wrap
      do_reset();
      @(negedge clk);
      force dut_le.r_word_cnt = 16'hFFFF;
      force dut_be.r_word_cnt = 16'hFFFF;
      @(negedge clk);
      release dut_le.r_word_cnt;
      release dut_be.r_word_cnt;
      m_cnt_le = 16'hFFFF;
      m_cnt_be = 16'hFFFF;
      send_word(8'h00, 8'h00, 8'hC0, 8'h7F);
      idle();
      @(negedge clk);
      chk("t7_wrap_le", le_o_word_cnt, 16'd0);
      chk("t7_wrap_be", be_o_word_cnt, 16'd0);

      // byte handshake on the expiry cycle suppresses the timeout
      push_exp(8'h01, 8'h02, 8'h03, 8'h04);
      send_byte(8'h01);
      @(negedge clk);
      i_valid = 1'b0;
      repeat (6) @(negedge clk);
      send_byte(8'h02);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i_valid = 1'b0;
         chk("t7_no_timeout_le", le_o_timeout, 0);
         chk("t7_no_timeout_be", be_o_timeout, 0);
      end
      send_byte(8'h03);
      send_byte(8'h04);
      idle();
      repeat (4) @(negedge clk);

      chk("le_queue_empty", q_le.size(), 0);
      chk("be_queue_empty", q_be.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
